// File: rtl/ram_port_arbiter_pkg.sv
// Shared types, state constants and default parameters for the RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int RAM_LAT_DEF = 1;

  // FSM state encoding kept as plain constants for legacy tools.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_ACCESS = 2'd1;
  localparam arb_state_t ST_WAIT   = 2'd2;
  localparam arb_state_t ST_RESP   = 2'd3;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

  // WAIT counter width: wide enough to hold RAM_LAT-1, never narrower than 1 bit.
  function automatic int wait_cnt_w(input int lat);
    if (lat > 1) begin
      return $clog2(lat);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin picker. The most recent owner loses a tie; the history
// register only moves when the caller actually grants the pick.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_a,
  input  logic   req_b,
  input  logic   update,
  output logic   pick_valid,
  output owner_t pick
);

  owner_t last_owner_r;

  // Choose an owner from the eligible requests and the previous winner.
  always_comb begin
    pick_valid = req_a | req_b;
    pick       = OWN_CPU;
    if (req_a && req_b) begin
      if (last_owner_r == OWN_LD) begin
        pick = OWN_CPU;
      end else begin
        pick = OWN_LD;
      end
    end else if (req_b) begin
      pick = OWN_LD;
    end else begin
      pick = OWN_CPU;
    end
  end

  // Remember the last granted owner; reset favours the CPU on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_r <= OWN_LD;
    end else if (update) begin
      last_owner_r <= pick;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous single-port RAM between the CPU memory path and the
// loader/debug port, one transaction at a time. All outputs are registered.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RAM_LAT = RAM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int               CNT_W     = wait_cnt_w(RAM_LAT);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(RAM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arb_state_t       state_r;
  owner_t           owner_r;
  logic             we_r;
  logic [CNT_W-1:0] wait_cnt_r;

  logic   cpu_elig;
  logic   grant_en;
  logic   pick_valid;
  owner_t pick_owner;

  // The lock only masks new CPU grants; a CPU transaction already past IDLE finishes.
  assign cpu_elig = cpu_req & ~ld_lock;
  assign grant_en = (state_r == ST_IDLE) & pick_valid;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req_a      (cpu_elig),
    .req_b      (ld_req),
    .update     (grant_en),
    .pick_valid (pick_valid),
    .pick       (pick_owner)
  );

  // Transaction sequencer: accept, drive RAM for one cycle, wait out latency, respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_CPU;
      we_r       <= 1'b0;
      wait_cnt_r <= {CNT_W{1'b0}};
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ld_gnt     <= 1'b0;
      ld_rvalid  <= 1'b0;
      rdata      <= {DATA_W{1'b0}};
      busy       <= 1'b0;
      ram_addr   <= {ADDR_W{1'b0}};
      ram_data   <= {DATA_W{1'b0}};
      ram_wren   <= 1'b0;
    end else begin
      cpu_gnt    <= 1'b0;
      ld_gnt     <= 1'b0;
      cpu_rvalid <= 1'b0;
      ld_rvalid  <= 1'b0;
      ram_wren   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_en) begin
            state_r <= ST_ACCESS;
            busy    <= 1'b1;
            owner_r <= pick_owner;
            if (pick_owner == OWN_CPU) begin
              ram_addr <= cpu_addr;
              ram_data <= cpu_wdata;
              ram_wren <= cpu_we;
              we_r     <= cpu_we;
              cpu_gnt  <= 1'b1;
            end else begin
              ram_addr <= ld_addr;
              ram_data <= ld_wdata;
              ram_wren <= ld_we;
              we_r     <= ld_we;
              ld_gnt   <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // The RAM samples address/data/wren at the edge that leaves ACCESS.
          if (we_r) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == LAST_WAIT) begin
            rdata   <= ram_q;
            state_r <= ST_RESP;
            if (owner_r == OWN_CPU) begin
              cpu_rvalid <= 1'b1;
            end else begin
              ld_rvalid <= 1'b1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
